// File: rtl/bullet_scheduler.sv
// ----------------------------------------------------------------------------
// bullet_scheduler
//
// Manages the shared pool of bullet slots for the single vertical firing lane.
// Fire requests from the player gun and the enemy gun are arbitrated and given
// a free slot. On every movement tick, each live bullet moves one row. Bullets
// that leave the screen are then freed, and so are player/enemy bullets that
// have met. Hit and clash events are pulsed toward game logic and the VGA
// bullet renderer.
//
// Ports
//   clock       system clock
//   reset       synchronous, active-high reset
//   p_fire_req  player fire request, held high until acked
//   e_fire_req  enemy fire request, held high until acked
//   p_fire_ack  one-cycle pulse: a player bullet was allocated
//   e_fire_ack  one-cycle pulse: an enemy bullet was allocated
//   slot_valid  slot i holds a live bullet
//   slot_enemy  owner of slot i (1 = enemy, 0 = player)
//   slot_y      y of slot i at bits [i*Y_W +: Y_W]; row 0 is the top
//   hit_player  one-cycle pulse: an enemy bullet passed the bottom row
//   hit_enemy   one-cycle pulse: a player bullet passed row 0
//   clash       one-cycle pulse: a player/enemy bullet pair was destroyed
//   busy        a movement/collision pass is in progress
//   full        every slot is occupied
// ----------------------------------------------------------------------------
module bullet_scheduler #(
    parameter int SLOTS    = 4,
    parameter int Y_W      = 7,
    parameter int Y_MAX    = 119,
    parameter int TICK_DIV = 833333,
    parameter int COOLDOWN = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 p_fire_req,
    input  logic                 e_fire_req,
    output logic                 p_fire_ack,
    output logic                 e_fire_ack,
    output logic [SLOTS-1:0]     slot_valid,
    output logic [SLOTS-1:0]     slot_enemy,
    output logic [SLOTS*Y_W-1:0] slot_y,
    output logic                 hit_player,
    output logic                 hit_enemy,
    output logic                 clash,
    output logic                 busy,
    output logic                 full
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int IDX_W = $clog2(SLOTS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN);
    localparam logic [CD_W-1:0]  CD_ONE   = 1;
    localparam logic [Y_W-1:0]   Y_BOTTOM = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0]   Y_ONE    = 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLOTS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;

    typedef enum logic [1:0] {IDLE, MOVE, CHECK} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic [CD_W-1:0]    cd_p_q, cd_p_d, cd_e_q, cd_e_d;
    logic               rr_q, rr_d;
    logic [SLOTS-1:0]   valid_q, valid_d, enemy_q, enemy_d;
    logic [Y_W-1:0]     y_q [SLOTS];
    logic [Y_W-1:0]     y_d [SLOTS];
    logic               p_ack_q, p_ack_d, e_ack_q, e_ack_d;
    logic               hit_p_q, hit_p_d, hit_e_q, hit_e_d, clash_q, clash_d;

    logic               tick, elig_p, elig_e, grant_p, grant_e;
    logic [IDX_W-1:0]   free_idx, pair_p, pair_e;
    logic               pair_found;

    assign tick   = (cnt_q == CNT_LAST);
    assign full   = &valid_q;
    assign busy   = (state_q != IDLE);
    assign elig_p = p_fire_req && (cd_p_q == '0) && !full;
    assign elig_e = e_fire_req && (cd_e_q == '0) && !full;

    // Lowest-index free slot. The scan runs downward so the lowest hit wins.
    always_comb begin
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    // Colliding pair with the lowest player index, ties broken by the lowest
    // enemy index. An enemy bullet at or below a player bullet means they crossed.
    always_comb begin
        pair_found = 1'b0;
        pair_p     = '0;
        pair_e     = '0;
        for (int p = SLOTS - 1; p >= 0; p--) begin
            for (int e = SLOTS - 1; e >= 0; e--) begin
                if (valid_q[p] && !enemy_q[p] && valid_q[e] && enemy_q[e] &&
                    (y_q[e] >= y_q[p])) begin
                    pair_found = 1'b1;
                    pair_p     = IDX_W'(p);
                    pair_e     = IDX_W'(e);
                end
            end
        end
    end

    // Next-state logic: FSM, slot updates, pulses, tick and cooldown bookkeeping.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        enemy_d   = enemy_q;
        y_d       = y_q;
        pending_d = pending_q;
        cd_p_d    = cd_p_q;
        cd_e_d    = cd_e_q;
        rr_d      = rr_q;
        p_ack_d   = 1'b0;
        e_ack_d   = 1'b0;
        hit_p_d   = 1'b0;
        hit_e_d   = 1'b0;
        clash_d   = 1'b0;
        grant_p   = 1'b0;
        grant_e   = 1'b0;
        cnt_d     = tick ? '0 : cnt_q + CNT_ONE;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    idx_d     = '0;
                    state_d   = MOVE;
                end else begin
                    // The round-robin pointer only matters, and only moves, on a real contest.
                    if (elig_p && elig_e) begin
                        grant_p = ~rr_q;
                        grant_e = rr_q;
                        rr_d    = ~rr_q;
                    end else begin
                        grant_p = elig_p;
                        grant_e = elig_e;
                    end
                    if (grant_p || grant_e) begin
                        valid_d[free_idx] = 1'b1;
                        enemy_d[free_idx] = grant_e;
                        y_d[free_idx]     = grant_e ? '0 : Y_BOTTOM;
                    end
                    p_ack_d = grant_p;
                    e_ack_d = grant_e;
                end
            end
            MOVE: begin
                // Bounds are tested before stepping, so y never wraps.
                if (valid_q[idx_q]) begin
                    if (!enemy_q[idx_q]) begin
                        if (y_q[idx_q] == '0) begin
                            valid_d[idx_q] = 1'b0;
                            hit_e_d        = 1'b1;
                        end else begin
                            y_d[idx_q] = y_q[idx_q] - Y_ONE;
                        end
                    end else begin
                        if (y_q[idx_q] == Y_BOTTOM) begin
                            valid_d[idx_q] = 1'b0;
                            hit_p_d        = 1'b1;
                        end else begin
                            y_d[idx_q] = y_q[idx_q] + Y_ONE;
                        end
                    end
                end
                if (idx_q == IDX_LAST) state_d = CHECK;
                else                   idx_d   = idx_q + IDX_ONE;
            end
            CHECK: begin
                if (pair_found) begin
                    valid_d[pair_p] = 1'b0;
                    valid_d[pair_e] = 1'b0;
                    clash_d         = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh tick wins over the consume in IDLE; ticks merge, they never queue.
        if (tick) begin
            pending_d = 1'b1;
            if (cd_p_q != '0) cd_p_d = cd_p_q - CD_ONE;
            if (cd_e_q != '0) cd_e_d = cd_e_q - CD_ONE;
        end
        if (grant_p) cd_p_d = CD_LOAD;
        if (grant_e) cd_e_d = CD_LOAD;
    end

    // State register with synchronous reset that drops everything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            cd_p_q    <= '0;
            cd_e_q    <= '0;
            rr_q      <= 1'b0;
            valid_q   <= '0;
            enemy_q   <= '0;
            for (int i = 0; i < SLOTS; i++) y_q[i] <= '0;
            p_ack_q   <= 1'b0;
            e_ack_q   <= 1'b0;
            hit_p_q   <= 1'b0;
            hit_e_q   <= 1'b0;
            clash_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            cd_p_q    <= cd_p_d;
            cd_e_q    <= cd_e_d;
            rr_q      <= rr_d;
            valid_q   <= valid_d;
            enemy_q   <= enemy_d;
            for (int i = 0; i < SLOTS; i++) y_q[i] <= y_d[i];
            p_ack_q   <= p_ack_d;
            e_ack_q   <= e_ack_d;
            hit_p_q   <= hit_p_d;
            hit_e_q   <= hit_e_d;
            clash_q   <= clash_d;
        end
    end

    // Flatten the slot y registers for the renderer.
    always_comb begin
        slot_y = '0;
        for (int i = 0; i < SLOTS; i++) slot_y[i*Y_W +: Y_W] = y_q[i];
    end

    assign slot_valid = valid_q;
    assign slot_enemy = enemy_q;
    assign p_fire_ack = p_ack_q;
    assign e_fire_ack = e_ack_q;
    assign hit_player = hit_p_q;
    assign hit_enemy  = hit_e_q;
    assign clash      = clash_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// ----------------------------------------------------------------------------
// tb_bullet_scheduler
//
// Randomized bench for bullet_scheduler. A behavioural model resolves each
// movement tick as a whole: all bullets move, then colliding pairs are removed.
// From that result it predicts the clock cycle of every ack, hit, clash and
// end-of-pass event. Those predictions go into a queue. An independent monitor
// pops an entry whenever the DUT shows an event and compares the two.
// ----------------------------------------------------------------------------
module tb_bullet_scheduler;

    localparam int SLOTS      = 4;
    localparam int Y_W        = 7;
    localparam int Y_MAX      = 119;
    localparam int TICK_DIV   = 8;
    localparam int COOLDOWN   = 2;
    localparam int RUN_CYCLES = 12000;
    localparam int PHASE_LEN  = 1500;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 p_fire_req = 1'b0;
    logic                 e_fire_req = 1'b0;
    logic                 p_fire_ack, e_fire_ack;
    logic [SLOTS-1:0]     slot_valid, slot_enemy;
    logic [SLOTS*Y_W-1:0] slot_y;
    logic                 hit_player, hit_enemy, clash, busy, full;

    bullet_scheduler #(
        .SLOTS(SLOTS), .Y_W(Y_W), .Y_MAX(Y_MAX), .TICK_DIV(TICK_DIV), .COOLDOWN(COOLDOWN)
    ) dut (
        .clock(clock), .reset(reset),
        .p_fire_req(p_fire_req), .e_fire_req(e_fire_req),
        .p_fire_ack(p_fire_ack), .e_fire_ack(e_fire_ack),
        .slot_valid(slot_valid), .slot_enemy(slot_enemy), .slot_y(slot_y),
        .hit_player(hit_player), .hit_enemy(hit_enemy), .clash(clash),
        .busy(busy), .full(full)
    );

    always #5 clock = ~clock;

    // Edge counter, plus the reset value that the most recent edge saw.
    int   cyc = 0;
    logic rst_at_edge = 1'b1;
    always @(posedge clock) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    typedef struct {
        int                   edge_no;
        bit                   pa, ea, hp, he, cl, fall;
        bit                   chk;
        logic [SLOTS-1:0]     v, en;
        logic [SLOTS*Y_W-1:0] y;
    } rec_t;

    rec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    bit m_v  [SLOTS];
    bit m_en [SLOTS];
    int m_y  [SLOTS];
    int m_cnt, m_cd_p, m_cd_e, m_busy_end;
    bit m_pending, m_rr;
    bit p_granted, e_granted;
    int p_dens, e_dens;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, actual, expected);
        end
    endtask

    function automatic void push_event(input int e, input bit pa, input bit ea, input bit hp,
                                       input bit he, input bit cl, input bit fall, input bit chk);
        rec_t r;
        r.edge_no = e;
        r.pa = pa; r.ea = ea; r.hp = hp; r.he = he; r.cl = cl; r.fall = fall; r.chk = chk;
        r.y = '0;
        for (int i = 0; i < SLOTS; i++) begin
            r.v[i]             = m_v[i];
            r.en[i]            = m_en[i];
            r.y[i*Y_W +: Y_W]  = Y_W'(m_y[i]);
        end
        sb.push_back(r);
    endfunction

    function automatic logic [63:0] pack_slots(input logic f, input logic [SLOTS-1:0] v,
                                               input logic [SLOTS-1:0] en, input logic [SLOTS*Y_W-1:0] y,
                                               input logic [SLOTS-1:0] mask);
        logic [SLOTS*Y_W-1:0] ym;
        ym = '0;
        for (int i = 0; i < SLOTS; i++) if (mask[i]) ym[i*Y_W +: Y_W] = y[i*Y_W +: Y_W];
        return 64'({f, v, en, ym});
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_v[i] = 0; m_en[i] = 0; m_y[i] = 0;
        end
        m_cnt = 0; m_cd_p = 0; m_cd_e = 0; m_pending = 0; m_rr = 0;
        m_busy_end = cyc;
        p_granted = 0; e_granted = 0;
    endfunction

    // Resolve one movement tick starting at edge e. All bullets move, then pairs
    // are removed. Each event is stamped with the cycle it is expected on.
    function automatic void model_tick(input int e);
        int n, pp, ee;
        for (int i = 0; i < SLOTS; i++) begin
            if (m_v[i]) begin
                if (!m_en[i]) begin
                    if (m_y[i] == 0) begin m_v[i] = 0; push_event(e + 1 + i, 0, 0, 0, 1, 0, 0, 0); end
                    else m_y[i] = m_y[i] - 1;
                end else begin
                    if (m_y[i] == Y_MAX) begin m_v[i] = 0; push_event(e + 1 + i, 0, 0, 1, 0, 0, 0, 0); end
                    else m_y[i] = m_y[i] + 1;
                end
            end
        end
        n = 0;
        do begin
            pp = -1; ee = -1;
            for (int p = 0; p < SLOTS; p++)
                for (int q = 0; q < SLOTS; q++)
                    if (pp < 0 && m_v[p] && !m_en[p] && m_v[q] && m_en[q] && m_y[q] >= m_y[p]) begin
                        pp = p; ee = q;
                    end
            if (pp >= 0) begin
                m_v[pp] = 0; m_v[ee] = 0;
                push_event(e + SLOTS + 1 + n, 0, 0, 0, 0, 1, 0, 0);
                n++;
            end
        end while (pp >= 0);
        m_busy_end = e + SLOTS + 1 + n;
        push_event(m_busy_end, 0, 0, 0, 0, 0, 1, 1);
    endfunction

    // Predict what happens at edge e, using the requests currently driven.
    function automatic void model_step(input int e);
        bit tick_now, full_now, elig_p, elig_e;
        int slot;
        tick_now  = (m_cnt == TICK_DIV - 1);
        p_granted = 0;
        e_granted = 0;
        if (e > m_busy_end) begin
            if (m_pending) begin
                m_pending = 0;
                model_tick(e);
            end else begin
                full_now = 1;
                for (int i = 0; i < SLOTS; i++) if (!m_v[i]) full_now = 0;
                elig_p = p_fire_req && (m_cd_p == 0) && !full_now;
                elig_e = e_fire_req && (m_cd_e == 0) && !full_now;
                if (elig_p && elig_e) begin
                    if (!m_rr) p_granted = 1; else e_granted = 1;
                    m_rr = !m_rr;
                end else begin
                    p_granted = elig_p;
                    e_granted = elig_e;
                end
                if (p_granted || e_granted) begin
                    slot = -1;
                    for (int i = 0; i < SLOTS; i++) if (!m_v[i] && slot < 0) slot = i;
                    m_v[slot]  = 1;
                    m_en[slot] = e_granted;
                    m_y[slot]  = e_granted ? 0 : Y_MAX;
                    push_event(e, p_granted, e_granted, 0, 0, 0, 0, 1);
                end
            end
        end
        if (tick_now) begin
            m_pending = 1;
            if (m_cd_p > 0) m_cd_p--;
            if (m_cd_e > 0) m_cd_e--;
        end
        if (p_granted) m_cd_p = COOLDOWN;
        if (e_granted) m_cd_e = COOLDOWN;
        m_cnt = (m_cnt + 1) % TICK_DIV;
    endfunction

    // Requesters hold req until acked. They occasionally give up early, and
    // re-request at a rate that varies from phase to phase.
    task automatic applyStimulus();
        if (p_granted) p_fire_req = 1'b0;
        else if (p_fire_req && $urandom_range(0, 49) == 0) p_fire_req = 1'b0;
        else if (!p_fire_req && $urandom_range(1, 8) <= p_dens) p_fire_req = 1'b1;
        if (e_granted) e_fire_req = 1'b0;
        else if (e_fire_req && $urandom_range(0, 49) == 0) e_fire_req = 1'b0;
        else if (!e_fire_req && $urandom_range(1, 8) <= e_dens) e_fire_req = 1'b1;
        model_step(cyc + 1);
    endtask

    task automatic assertReset();
        reset = 1'b1;
        while (sb.size() > 0 && sb[sb.size()-1].edge_no > cyc) sb.delete(sb.size() - 1);
    endtask

    // Monitor: compares every DUT event against the oldest prediction.
    initial begin : monitor
        bit   prev_busy, fall, fire;
        rec_t r;
        prev_busy = 0;
        forever begin
            @(negedge clock);
            if (rst_at_edge) begin
                prev_busy = 0;
                checkOutput("reset_state",
                    64'({p_fire_ack, e_fire_ack, hit_player, hit_enemy, clash, busy, full,
                         slot_valid, slot_enemy, slot_y}), 64'd0);
            end else begin
                fall = prev_busy && !busy;
                fire = p_fire_ack || e_fire_ack || hit_player || hit_enemy || clash || fall;
                while (sb.size() > 0 && sb[0].edge_no < cyc) begin
                    total++; bad++;
                    $display("[TB] FAIL missed_event at cycle %0d: actual=none required=event at cycle %0d",
                             cyc, sb[0].edge_no);
                    sb.delete(0);
                end
                if (fire) begin
                    if (sb.size() > 0 && sb[0].edge_no == cyc) begin
                        r = sb.pop_front();
                        checkOutput("event_bits",
                            64'({p_fire_ack, e_fire_ack, hit_player, hit_enemy, clash, fall}),
                            64'({r.pa, r.ea, r.hp, r.he, r.cl, r.fall}));
                        if (r.chk)
                            checkOutput("slot_state",
                                pack_slots(full, slot_valid, slot_enemy, slot_y, r.v),
                                pack_slots(&r.v, r.v, r.en, r.y, r.v));
                    end else begin
                        total++; bad++;
                        $display("[TB] FAIL unexpected_event at cycle %0d: actual=%b required=no event",
                                 cyc, {p_fire_ack, e_fire_ack, hit_player, hit_enemy, clash, fall});
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin : stimulus
        int w;
        p_dens = 0; e_dens = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        p_dens = 4;
        applyStimulus();

        for (int c = 0; c < RUN_CYCLES; c++) begin
            @(posedge clock); #1;
            if (c % PHASE_LEN == 0) begin
                p_dens = (c / PHASE_LEN == 1) ? 0 : int'($urandom_range(1, 8));
                e_dens = (c / PHASE_LEN == 0) ? 0 : int'($urandom_range(1, 8));
            end
            if (reset) begin
                reset = 1'b0;
                model_reset();
                applyStimulus();
            end else if (cyc + 1 <= m_busy_end && $urandom_range(0, 1999) == 0) begin
                assertReset();
            end else begin
                applyStimulus();
            end
        end

        // Ensure a reset lands while a movement pass is in flight.
        if (reset) begin
            @(posedge clock); #1;
            reset = 1'b0;
            model_reset();
        end
        p_dens = 8; e_dens = 8;
        w = 0;
        do begin
            if (w > 0) begin @(posedge clock); #1; end
            applyStimulus();
            w++;
        end while (w < 64 && !(cyc + 2 <= m_busy_end && cyc + 1 > m_busy_end - SLOTS - 1));
        @(posedge clock); #1;
        assertReset();
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();

        // Drain with no requests so every outstanding prediction resolves.
        p_dens = 0; e_dens = 0;
        p_fire_req = 1'b0; e_fire_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin @(posedge clock); #1; end
            applyStimulus();
        end
        @(negedge clock); #1;
        while (sb.size() > 0 && sb[0].edge_no <= cyc) begin
            total++; bad++;
            $display("[TB] FAIL unconsumed_event: actual=none required=event at cycle %0d", sb[0].edge_no);
            sb.delete(0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
